// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
//   Shared FPU definitions for the float-to-integer result path. It holds:
//   - IEEE-754 single-precision field positions and exponent thresholds
//   - the INT32 saturation values and the one in-range negative boundary
//     operand
//   - the packed entry type buffered by the result stage
//   No ports. Import with `import fpu_pkg::*;`.
// -----------------------------------------------------------------------------
package fpu_pkg;

  // F32 field layout
  localparam int F32_SIGN_BIT = 31;
  localparam int F32_EXP_MSB  = 30;
  localparam int F32_EXP_LSB  = 23;
  localparam int F32_MAN_MSB  = 22;

  // Exponent landmarks (biased)
  localparam logic [7:0] F32_EXP_BIAS  = 8'd127;  // |x| >= 1.0 from here on
  localparam logic [7:0] F32_EXACT_EXP = 8'd150;  // no fraction bits remain
  localparam logic [7:0] F32_OVF_EXP   = 8'd158;  // |x| >= 2^31
  localparam logic [7:0] F32_EXP_MAX   = 8'd255;  // Inf / NaN

  // INT32 saturation values
  localparam logic [31:0] INT32_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_NEG_SAT = 32'h8000_0000;

  // -2^31 exactly: the exponent says overflow, but the value is representable
  localparam logic [31:0] NEG_MIN_F32 = 32'hCF00_0000;

  // Width of the tag field held in each buffered entry. The result stage's
  // TAG_W parameter should match this.
  localparam int F2I_TAG_W = 4;

  typedef struct packed {
    logic [31:0]          data;
    logic [F2I_TAG_W-1:0] tag;
    logic                 nv;
    logic                 nx;
  } f2i_entry_t;

endpackage

// File: rtl/fpu_f2i_result_stage_if.sv
// -----------------------------------------------------------------------------
// fpu_f2i_result_stage_if
//   Handshake bundle for the F32->INT result stage.
//   Input side : IN_VALID/IN_READY with operand IN_A, converter result IN_O,
//                and tag IN_TAG.
//   Output side: OUT_VALID/OUT_READY with OUT_DATA, OUT_TAG, and the
//                OUT_NV/OUT_NX exception flags.
//   master : producer/consumer environment (drives IN_*, OUT_READY)
//   slave  : the result stage
// -----------------------------------------------------------------------------
interface fpu_f2i_result_stage_if #(
  parameter int TAG_W = 4
) ();

  logic             IN_VALID;
  logic             IN_READY;
  logic [31:0]      IN_A;
  logic [31:0]      IN_O;
  logic [TAG_W-1:0] IN_TAG;

  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      OUT_DATA;
  logic [TAG_W-1:0] OUT_TAG;
  logic             OUT_NV;
  logic             OUT_NX;

  modport master (
    output IN_VALID, IN_A, IN_O, IN_TAG, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_TAG, OUT_NV, OUT_NX
  );

  modport slave (
    input  IN_VALID, IN_A, IN_O, IN_TAG, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_TAG, OUT_NV, OUT_NX
  );

endinterface

// File: rtl/fpu_f2i_classify.sv
// -----------------------------------------------------------------------------
// fpu_f2i_classify
//   Purely combinational classification of an F32 operand that was converted
//   to INT32 with round-toward-zero. It picks the final integer (either the
//   converter output or a saturation value) and computes the invalid (NV) and
//   inexact (NX) flags.
//   Ports:
//     in_a     : original F32 operand
//     in_o     : converter output for in_a
//     res_data : final signed integer
//     res_nv   : invalid (NaN or out of INT32 range)
//     res_nx   : inexact (fraction bits were discarded); only set if !res_nv
// -----------------------------------------------------------------------------
module fpu_f2i_classify
  import fpu_pkg::*;
(
  input  logic [31:0] in_a,
  input  logic [31:0] in_o,
  output logic [31:0] res_data,
  output logic        res_nv,
  output logic        res_nx
);

  logic        sign;
  logic [7:0]  exp_f;
  logic [22:0] man;
  logic        is_nan;
  logic        is_neg_min;
  logic        is_ovf;
  logic [7:0]  frac_shift;
  logic [22:0] frac_mask;

  assign sign  = in_a[F32_SIGN_BIT];
  assign exp_f = in_a[F32_EXP_MSB:F32_EXP_LSB];
  assign man   = in_a[F32_MAN_MSB:0];

  assign is_nan     = (exp_f == F32_EXP_MAX) && (man != '0);
  assign is_neg_min = (in_a == NEG_MIN_F32);
  // Includes +/-Inf (exponent 255); NaN is resolved first below.
  assign is_ovf     = (exp_f >= F32_OVF_EXP);

  // For 127 <= e <= 149 the low (150 - e) mantissa bits lie below the binary
  // point; the mask selects exactly those. Shifts of 23 or more give zero,
  // which is harmless because the mask is only used inside that range.
  assign frac_shift = exp_f - F32_EXP_BIAS;
  assign frac_mask  = 23'h7F_FFFF >> frac_shift;

  always_comb begin
    res_data = in_o;
    res_nv   = 1'b0;
    res_nx   = 1'b0;
    if (is_nan) begin
      res_data = INT32_POS_SAT;
      res_nv   = 1'b1;
    end else if (is_neg_min) begin
      // -2^31 converts exactly; trust the converter.
      res_data = in_o;
    end else if (is_ovf) begin
      res_data = sign ? INT32_NEG_SAT : INT32_POS_SAT;
      res_nv   = 1'b1;
    end else if (exp_f < F32_EXP_BIAS) begin
      // |x| < 1: anything non-zero (including denormals) is lost entirely.
      res_nx = (in_a[30:0] != '0);
    end else if (exp_f < F32_EXACT_EXP) begin
      res_nx = |(man & frac_mask);
    end
  end

endmodule

// File: rtl/fpu_f2i_result_stage.sv
// -----------------------------------------------------------------------------
// fpu_f2i_result_stage
//   Registered result stage behind the combinational F32->INT converter.
//   Each accepted operand/result pair is classified (saturation, NV, NX) and
//   pushed into a DEPTH-entry in-order FIFO toward writeback. On every output
//   commit, the committed flags are accumulated into sticky FLAGS, and invalid
//   commits are counted in a saturating 16-bit counter.
//   Parameters:
//     TAG_W : tag width (should equal fpu_pkg::F2I_TAG_W)
//     DEPTH : FIFO entries, power of two, >= 2
//   Ports:
//     CLK, nRST : clock, asynchronous active-low reset
//     bus       : slave side of the IN_*/OUT_* valid/ready bundle
//     FLAG_CLR  : clear sticky flags and counter (a same-cycle commit survives)
//     FLAGS     : sticky {NV, NX}
//     NV_COUNT  : committed-invalid count, saturates at 0xFFFF
// -----------------------------------------------------------------------------
module fpu_f2i_result_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = F2I_TAG_W,
  parameter int DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  fpu_f2i_result_stage_if.slave bus,
  input  logic                 FLAG_CLR,
  output logic [1:0]           FLAGS,
  output logic [15:0]          NV_COUNT
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  f2i_entry_t   fifo_q [DEPTH];
  f2i_entry_t   fifo_d [DEPTH];
  logic [1:0]   flags_q, flags_d;
  logic [15:0]  nv_count_q, nv_count_d;

  logic [31:0]  cls_data;
  logic         cls_nv;
  logic         cls_nx;
  f2i_entry_t   new_entry;
  f2i_entry_t   head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [1:0]   commit_flags;
  logic         commit_nv;

  fpu_f2i_classify u_classify (
    .in_a     (bus.IN_A),
    .in_o     (bus.IN_O),
    .res_data (cls_data),
    .res_nv   (cls_nv),
    .res_nx   (cls_nx)
  );

  always_comb begin
    new_entry      = '0;
    new_entry.data = cls_data;
    new_entry.tag  = F2I_TAG_W'(bus.IN_TAG);
    new_entry.nv   = cls_nv;
    new_entry.nx   = cls_nx;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // IN_READY comes from registered pointers only; a pop in the same cycle
  // does not open a slot until the next cycle.
  assign push = bus.IN_VALID && !full;
  assign pop  = !empty && bus.OUT_READY;

  assign head = fifo_q[rd_ptr_q[AW-1:0]];

  assign bus.IN_READY  = !full;
  assign bus.OUT_VALID = !empty;
  assign bus.OUT_DATA  = head.data;
  assign bus.OUT_TAG   = TAG_W'(head.tag);
  assign bus.OUT_NV    = head.nv;
  assign bus.OUT_NX    = head.nx;

  assign FLAGS    = flags_q;
  assign NV_COUNT = nv_count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fifo_d   = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = new_entry;
      wr_ptr_d                 = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Status accumulates on commit, not on accept. A clear that coincides with
  // a commit keeps that commit's contribution.
  always_comb begin
    commit_flags = pop ? {head.nv, head.nx} : 2'b00;
    commit_nv    = pop && head.nv;
    flags_d      = flags_q | commit_flags;
    nv_count_d   = nv_count_q;
    if (FLAG_CLR) begin
      flags_d    = commit_flags;
      nv_count_d = commit_nv ? 16'd1 : 16'd0;
    end else if (commit_nv && (nv_count_q != 16'hFFFF)) begin
      nv_count_d = nv_count_q + 16'd1;
    end
  end

  // Asynchronous reset discards buffered entries at once, so OUT_VALID drops
  // without waiting for a clock edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      flags_q    <= '0;
      nv_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      flags_q    <= flags_d;
      nv_count_q <= nv_count_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_fpu_f2i_result_stage.sv
// -----------------------------------------------------------------------------
// tb_fpu_f2i_result_stage
//   Scoreboard bench for fpu_f2i_result_stage: directed operands with
//   hand-computed results, a queue of expected entries, and a monitor that pops
//   and compares on every output commit.
// -----------------------------------------------------------------------------
module tb_fpu_f2i_result_stage;

  localparam int TAG_W = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        FLAG_CLR = 1'b0;
  logic [1:0]  FLAGS;
  logic [15:0] NV_COUNT;

  fpu_f2i_result_stage_if #(.TAG_W(TAG_W)) bus ();

  fpu_f2i_result_stage #(.TAG_W(TAG_W), .DEPTH(2)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus.slave),
    .FLAG_CLR (FLAG_CLR),
    .FLAGS    (FLAGS),
    .NV_COUNT (NV_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    logic             nv;
    logic             nx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drives one operand starting at a negative edge and waits (bounded) for
  // IN_READY. Returns at the negative edge after the accepting edge with
  // IN_VALID still high, so back-to-back calls give full throughput.
  task automatic send(input logic [31:0] a, input logic [31:0] o, input logic [TAG_W-1:0] tag,
                      input logic [31:0] ed, input logic env, input logic enx);
    int   n;
    exp_t e;
    n = 0;
    bus.IN_VALID = 1'b1;
    bus.IN_A     = a;
    bus.IN_O     = o;
    bus.IN_TAG   = tag;
    while (!bus.IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!bus.IN_READY) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag %0d got IN_READY=0 want 1 within 20 cycles", tag);
      bus.IN_VALID = 1'b0;
    end else begin
      e.d  = ed;
      e.t  = tag;
      e.nv = env;
      e.nx = enx;
      sb.push_back(e);
      @(negedge CLK);
    end
  endtask

  task automatic idle();
    bus.IN_VALID = 1'b0;
  endtask

  // Monitor: samples just after the falling edge, once stimulus for the cycle
  // is settled and well before the next rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (nRST && bus.OUT_VALID && bus.OUT_READY) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got tag=%0d data=%h want no output", bus.OUT_TAG, bus.OUT_DATA);
        end else begin
          e = sb.pop_front();
          if (bus.OUT_DATA !== e.d || bus.OUT_TAG !== e.t || bus.OUT_NV !== e.nv || bus.OUT_NX !== e.nx) begin
            bad++;
            $display("FAIL pop_entry: got data=%h tag=%0d nv=%b nx=%b want data=%h tag=%0d nv=%b nx=%b",
                     bus.OUT_DATA, bus.OUT_TAG, bus.OUT_NV, bus.OUT_NX, e.d, e.t, e.nv, e.nx);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.IN_VALID  = 1'b0;
    bus.IN_A      = '0;
    bus.IN_O      = '0;
    bus.IN_TAG    = '0;
    bus.OUT_READY = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_out_data",  bus.OUT_DATA,  0);
    check("rst_out_tag",   bus.OUT_TAG,   0);
    check("rst_out_nv",    bus.OUT_NV,    0);
    check("rst_out_nx",    bus.OUT_NX,    0);
    check("rst_flags",     FLAGS,         0);
    check("rst_nv_count",  NV_COUNT,      0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", bus.IN_READY, 1);

    // 3.14159 -> 3, inexact; visible one cycle after accept
    bus.OUT_READY = 1'b1;
    send(32'h40490FDB, 32'd3, 4'd5, 32'd3, 1'b0, 1'b1);
    check("latency_out_valid", bus.OUT_VALID, 1);
    idle();
    @(negedge CLK);
    check("flags_after_pi", FLAGS, 2'b01);

    // NaN and -Inf saturate with NV
    send(32'h7FC00000, 32'h80000000, 4'd6, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'hFF800000, 32'h80000000, 4'd7, 32'h80000000, 1'b1, 1'b0);
    idle();
    repeat (2) @(negedge CLK);
    check("nv_count_after_nan_inf", NV_COUNT, 2);
    check("flags_after_nan_inf", FLAGS, 2'b11);

    // Boundary operands
    send(32'hCF000000, 32'h80000000, 4'd8,  32'h80000000, 1'b0, 1'b0); // -2^31 exact
    send(32'hCF000001, 32'h80000000, 4'd9,  32'h80000000, 1'b1, 1'b0); // just below -2^31
    send(32'h00000001, 32'h00000000, 4'd10, 32'h00000000, 1'b0, 1'b1); // denormal
    send(32'h4F000000, 32'h80000000, 4'd11, 32'h7FFFFFFF, 1'b1, 1'b0); // +2^31
    send(32'h41200000, 32'd10,       4'd12, 32'd10,       1'b0, 1'b0); // 10.0 exact
    send(32'h4B000001, 32'h00800001, 4'd13, 32'h00800001, 1'b0, 1'b0); // e=150, integral
    send(32'hBF000000, 32'h00000000, 4'd14, 32'h00000000, 1'b0, 1'b1); // -0.5
    idle();
    repeat (2) @(negedge CLK);
    check("nv_count_after_boundaries", NV_COUNT, 4);

    // Backpressure: two entries fill the FIFO, the third stalls
    bus.OUT_READY = 1'b0;
    send(32'h3F800000, 32'd1, 4'd1, 32'd1, 1'b0, 1'b0);
    send(32'h40000000, 32'd2, 4'd2, 32'd2, 1'b0, 1'b0);
    check("full_in_ready", bus.IN_READY, 0);
    bus.IN_A   = 32'h40400000;
    bus.IN_O   = 32'd3;
    bus.IN_TAG = 4'd3;
    @(negedge CLK);
    check("stall_in_ready", bus.IN_READY, 0);
    check("stall_out_valid", bus.OUT_VALID, 1);
    check("stall_head_tag", bus.OUT_TAG, 1);
    bus.OUT_READY = 1'b1;
    send(32'h40400000, 32'd3, 4'd3, 32'd3, 1'b0, 1'b0);
    check("drain_tag3_valid", bus.OUT_VALID, 1);
    check("drain_tag3_next", bus.OUT_TAG, 3);
    idle();
    @(negedge CLK);
    check("drain_empty", bus.OUT_VALID, 0);

    // Bring NV_COUNT to 7, then clear in the same cycle as an NV commit
    send(32'h7FC00001, 32'd0, 4'd4, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'h7F800000, 32'd0, 4'd5, 32'h7FFFFFFF, 1'b1, 1'b0);
    send(32'hFFC00000, 32'd0, 4'd6, 32'h7FFFFFFF, 1'b1, 1'b0);
    idle();
    repeat (2) @(negedge CLK);
    check("nv_count_seven", NV_COUNT, 7);
    bus.OUT_READY = 1'b0;
    send(32'h7FC00000, 32'd0, 4'd15, 32'h7FFFFFFF, 1'b1, 1'b0);
    idle();
    check("pre_clr_nv_count", NV_COUNT, 7);
    FLAG_CLR      = 1'b1;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    FLAG_CLR = 1'b0;
    check("clr_commit_flags", FLAGS, 2'b10);
    check("clr_commit_nv_count", NV_COUNT, 1);

    // Asynchronous reset with two buffered entries
    bus.OUT_READY = 1'b0;
    send(32'h3F800000, 32'd1, 4'd1, 32'd1, 1'b0, 1'b0);
    send(32'h40000000, 32'd2, 4'd2, 32'd2, 1'b0, 1'b0);
    idle();
    check("pre_reset_out_valid", bus.OUT_VALID, 1);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_out_valid", bus.OUT_VALID, 0);
    check("async_rst_flags", FLAGS, 0);
    check("async_rst_nv_count", NV_COUNT, 0);
    #1;
    nRST = 1'b1;
    sb.delete();
    @(negedge CLK);
    check("post_rst_in_ready", bus.IN_READY, 1);
    check("post_rst_out_valid", bus.OUT_VALID, 0);
    bus.OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    check("post_rst_no_stale", bus.OUT_VALID, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_f2i_result_stage.md
# fpu_f2i_result_stage

Registered result stage directly downstream of the combinational F32-to-INT converter. It captures the converter's integer output together with the original IEEE-754 operand, and computes the invalid (NV) and inexact (NX) exception flags. It saturates out-of-range and NaN results and buffers them in a small valid/ready FIFO toward writeback. It also maintains sticky exception flags and a saturating invalid-event counter for the FPU status register.

## Interface
- TAG_W, 4, width of the opaque tag carried alongside each result
- DEPTH, 2, output FIFO entries (power of two, >= 2)

- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  operand/result pair present
- IN_READY  out  1  stage can accept this cycle
- IN_A  in  32  original F32 operand (also drives the converter)
- IN_O  in  32  converter output (round-toward-zero), same cycle as IN_A
- IN_TAG  in  TAG_W  destination tag
- OUT_VALID  out  1  head entry valid
- OUT_READY  in  1  consumer accepts head
- OUT_DATA  out  32  final signed integer
- OUT_TAG  out  TAG_W  tag of head entry
- OUT_NV  out  1  head entry invalid
- OUT_NX  out  1  head entry inexact
- FLAG_CLR  in  1  clear sticky flags and counter
- FLAGS  out  2  sticky {NV, NX}
- NV_COUNT  out  16  committed-invalid count, saturating

## Operation
- Accept on IN_VALID && IN_READY. Classify IN_A, with e = IN_A[30:23] and m = IN_A[22:0]:
  - NaN: e==255 && m!=0 → NV=1, data 0x7FFFFFFF.
  - +overflow: sign 0 and (e>=158 or +Inf) → NV=1, data 0x7FFFFFFF.
  - -overflow: sign 1 and (e>=158 or -Inf), except IN_A==0xCF000000 → NV=1, data 0x80000000.
  - IN_A==0xCF000000 → data IN_O (0x80000000), NV=0, NX=0.
  - Otherwise data = IN_O, NV=0.
- NX (only when NV=0):
  - e<127: NX = (IN_A[30:0]!=0). This covers denormals and ±0.x values.
  - 127<=e<=149: NX = (m[149-e:0]!=0).
  - e>=150: NX=0.
- The entry {data, tag, NV, NX} is pushed into the FIFO.
- FIFO is in order, full-throughput, and has DEPTH entries. The pointer width is log2(DEPTH)+1, and pointers wrap modulo 2·DEPTH.
- Sticky flags and counter update on output commit (OUT_VALID && OUT_READY), not on accept.
  - FLAGS[1] |= OUT_NV and FLAGS[0] |= OUT_NX.
  - NV_COUNT increments on committed NV and holds at 0xFFFF.
- FLAG_CLR zeroes FLAGS and NV_COUNT. If a commit occurs in the same cycle, the commit's contribution survives: flags = commit flags, count = commit NV ? 1 : 0.

## Timing
- Reset values: OUT_VALID 0, OUT_DATA 0, OUT_TAG 0, OUT_NV 0, OUT_NX 0, FLAGS 0, NV_COUNT 0. After reset, IN_READY is 1.
- Latency: an operand accepted at edge t appears with OUT_VALID=1 in cycle t+1.
- IN_READY = !full, derived from registered pointers only. It has no combinational path from OUT_READY.
- Full FIFO with a simultaneous pop: no push that cycle, because IN_READY is already 0.
- Empty FIFO: there is no bypass; data always passes through a register.
- With OUT_READY held at 1, one result per cycle is sustained.
- OUT_* hold stable while OUT_VALID && !OUT_READY.
- IN_A/IN_O must be stable in the accept cycle only.
- nRST asserted mid-operation: all entries are discarded immediately (asynchronously), and OUT_VALID falls without waiting for a clock. Flags and counter clear.

## Structure
- Shared package fpu_pkg holds:
  - F32 field positions, exponent bias 127, and threshold 158.
  - INT32_POS_SAT 0x7FFFFFFF, INT32_NEG_SAT 0x80000000, and the NEG_MIN_F32 constant 0xCF000000.
  - A packed struct for the FIFO entry {data, tag, nv, nx}.
- One combinational sub-module, fpu_f2i_classify (IN_A, IN_O → data, nv, nx). It is reusable by a future F64 path.
- FIFO storage, pointers and flag logic stay in this module.

## Test plan
- IN_A=0x40490FDB (3.14159), IN_O=3, tag 5 → next cycle: OUT_DATA=3, OUT_TAG=5, NX=1, NV=0. After commit, FLAGS=2'b01.
- IN_A=0x7FC00000 (NaN) → OUT_DATA=0x7FFFFFFF, NV=1. Then IN_A=0xFF800000 (-Inf) → 0x80000000, NV=1. After both commit, NV_COUNT=2.
- IN_A=0xCF000000, IN_O=0x80000000 → OUT_DATA=0x80000000, NV=0, NX=0. Then IN_A=0xCF000001 → 0x80000000, NV=1. Also IN_A=0x00000001 (denormal), IN_O=0 → 0, NX=1.
- OUT_READY=0; push tags 1,2,3 back-to-back → IN_READY=0 after 2 accepts and tag 3 stalls. Release OUT_READY → outputs appear in order 1,2,3, one per cycle.
- FLAG_CLR asserted in the same cycle as an NV commit with NV_COUNT=7 → next cycle FLAGS[1]=1, NV_COUNT=1.
- Two entries buffered, nRST pulsed low between edges → OUT_VALID=0 immediately, FLAGS=0, NV_COUNT=0. After release, IN_READY=1 and no stale output appears.
